// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: FSM state encoding, address type and instruction constants.
package cpu_pkg;

    typedef logic [31:0] addr_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } fetch_state_e;

    localparam addr_t       DefaultResetPc = 32'h0000_0000;
    localparam logic [31:0] ZeroInstr      = 32'h0000_0000;
    localparam logic [31:0] NopInstr       = 32'h0000_0013;

    // Sequential fetch address; wraps modulo 2^32 with no flag.
    function automatic addr_t next_pc(addr_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {code, pc} pairs; flush empties it in one cycle.
// Depth must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       empty_o,
    output logic [$clog2(Depth):0]     count_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    // Pointer and occupancy update; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; no reset needed since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, req/gnt/rvalid instruction-memory master, output FIFO to decode.
// Optional misaligned-redirect trap enabled by defining IFU_MISALIGN_TRAP_EN.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter addr_t       RESET_PC  = DefaultResetPc,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_code,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);
    localparam int unsigned CntW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    addr_t           pc_q, pc_d;
    addr_t           fetch_addr_q, fetch_addr_d;
    logic            discard_q, discard_d;
    logic            fault_q, fault_d;
    addr_t           target_pc;
    logic            fifo_push, fifo_pop, fifo_empty;
    logic [63:0]     fifo_rdata;
    logic [CntW-1:0] fifo_count, occ_next;
    logic            can_fetch;

    // Redirect target, FIFO strobes and whether a new fetch may start next cycle.
    always_comb begin
        target_pc = redirect_pc;
`ifdef IFU_MISALIGN_TRAP_EN
        fault_d = redirect_valid ? (redirect_pc[1:0] != 2'b00) : fault_q;
`else
        target_pc[1:0] = 2'b00;
        fault_d = 1'b0;
`endif
        fifo_pop  = ~fifo_empty & inst_ready;
        // A response coinciding with a redirect belongs to the old stream.
        fifo_push = (state_q == StWait) & imem_rvalid & ~discard_q & ~redirect_valid;
        if (redirect_valid) occ_next = '0;
        else occ_next = fifo_count + CntW'(fifo_push) - CntW'(fifo_pop);
        can_fetch = (occ_next < CntW'(BUF_DEPTH)) & ~fault_d;
    end

    // Fetch FSM next state; at most one request outstanding, slot reserved before issue.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        discard_d    = discard_q;
        unique case (state_q)
            StIdle: begin
                if (can_fetch) state_d = StReq;
            end
            StReq: begin
                if (imem_gnt) begin
                    fetch_addr_d = pc_q;
                    pc_d         = next_pc(pc_q);
                    state_d      = StWait;
                    if (redirect_valid) discard_d = 1'b1;
                end else if (!can_fetch) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    discard_d = 1'b0;
                    state_d   = can_fetch ? StReq : StIdle;
                end else if (redirect_valid) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (redirect_valid) pc_d = target_pc;
    end

    // Fetch control registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            fetch_addr_q <= '0;
            discard_q    <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            discard_q    <= discard_d;
            fault_q      <= fault_d;
        end
    end

    fetch_fifo #(
        .Depth (BUF_DEPTH),
        .Width (64)
    ) u_fetch_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (fifo_push),
        .wdata_i ({imem_rdata, fetch_addr_q}),
        .pop_i   (fifo_pop),
        .flush_i (redirect_valid),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Outputs are decoded from registers only; data fields read zero when invalid.
    always_comb begin
        imem_req    = (state_q == StReq);
        imem_addr   = imem_req ? pc_q : '0;
        inst_valid  = ~fifo_empty;
        inst_code   = inst_valid ? fifo_rdata[63:32] : ZeroInstr;
        inst_pc     = inst_valid ? fifo_rdata[31:0] : '0;
        fetch_fault = fault_q;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed sequences, a redirect vector
// table and randomized traffic against a queue-based model of the instruction stream.
module tb_instruction_fetch_unit;
    localparam logic [31:0] ResetPc = 32'h0000_0000;
    localparam int          TbDepth = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_code;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    instruction_fetch_unit #(
        .RESET_PC  (ResetPc),
        .BUF_DEPTH (TbDepth)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_code      (inst_code),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] code; } ent_t;
    typedef struct { logic [31:0] target; logic [31:0] first; logic [31:0] second; bit fault; } redir_vec_t;

    int checks = 0;
    int failures = 0;

    // Stimulus knobs
    bit          drv_rst = 1'b0;
    bit          drv_ready = 1'b0;
    bit          drv_redir = 1'b0;
    bit          redir_on_gnt = 1'b0;
    logic [31:0] drv_target = '0;
    int          gnt_delay = 0;
    int          rv_extra = 0;

    // Memory model
    int          req_age = 0;
    bit          pend_valid = 1'b0;
    bit          pend_stale = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_cnt = 0;

    // Stream model
    ent_t        q[$];
    logic [31:0] gnt_log[$];
    logic [31:0] exp_fetch = ResetPc;
    bit          m_fault = 1'b0;
    bit          just_reset = 1'b1;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    bit          last_gnt = 1'b0;
    int          pops = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: check outputs at negedge, drive inputs, advance the model.
    task automatic step();
        bit          rv_now;
        bit          rv_stale;
        logic [31:0] rv_addr;
        bit          pop;
        bit          redir;
        @(negedge clk);
        chk("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("inst_pc", inst_pc, q[0].pc);
            chk("inst_code", inst_code, q[0].code);
        end else begin
            chk("inst_pc_zero", inst_pc, 32'h0);
            chk("inst_code_zero", inst_code, 32'h0);
        end
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        if (just_reset) begin
            chk("rst_req", 32'(imem_req), 32'h0);
            chk("rst_addr", imem_addr, 32'h0);
        end
        if (m_fault) chk("fault_no_req", 32'(imem_req), 32'h0);
        if (imem_req === 1'b1) chk("req_space", 32'(q.size() < TbDepth), 32'h1);
        if (prev_stall) begin
            chk("stall_req", 32'(imem_req), 32'h1);
            chk("stall_addr", imem_addr, prev_addr);
        end

        rst_n = ~drv_rst;
        inst_ready = drv_ready;
        rv_now = 1'b0;
        rv_stale = 1'b0;
        rv_addr = '0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        if (pend_valid) begin
            if (pend_cnt == 0) begin
                rv_now = 1'b1;
                rv_addr = pend_addr;
                rv_stale = pend_stale;
                imem_rvalid = 1'b1;
                imem_rdata = mem_word(pend_addr);
            end else begin
                pend_cnt--;
            end
        end
        imem_gnt = 1'b0;
        if (imem_req === 1'b1 && !pend_valid) begin
            if (req_age >= gnt_delay) imem_gnt = 1'b1;
            else req_age++;
        end
        if (imem_req !== 1'b1 || imem_gnt) req_age = 0;
        redir = drv_redir || (redir_on_gnt && imem_gnt);
        if (redir_on_gnt && imem_gnt) redir_on_gnt = 1'b0;
        redirect_valid = redir;
        redirect_pc = drv_target;
        drv_redir = 1'b0;

        pop = (inst_valid === 1'b1) && drv_ready;
        last_gnt = 1'b0;
        if (rv_now) pend_valid = 1'b0;
        if (drv_rst) begin
            q.delete();
            exp_fetch = ResetPc;
            m_fault = 1'b0;
            if (imem_gnt) begin
                pend_valid = 1'b1;
                pend_addr = imem_addr;
                pend_cnt = rv_extra;
            end
            pend_stale = 1'b1;
        end else begin
            if (imem_gnt) begin
                chk("fetch_addr", imem_addr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
                gnt_log.push_back(imem_addr);
                last_gnt = 1'b1;
                pend_valid = 1'b1;
                pend_addr = imem_addr;
                pend_cnt = rv_extra;
                pend_stale = redir;
            end else if (pend_valid && redir) begin
                pend_stale = 1'b1;
            end
            if (pop) begin
                void'(q.pop_front());
                pops++;
            end
            if (rv_now && !rv_stale && !redir) q.push_back('{pc: rv_addr, code: mem_word(rv_addr)});
            if (redir) begin
                q.delete();
`ifdef IFU_MISALIGN_TRAP_EN
                m_fault = (drv_target[1:0] != 2'b00);
                exp_fetch = drv_target;
`else
                m_fault = 1'b0;
                exp_fetch = {drv_target[31:2], 2'b00};
`endif
            end
        end
        just_reset = drv_rst;
        prev_stall = (imem_req === 1'b1) && !imem_gnt && !redir && !drv_rst;
        prev_addr = imem_addr;
        drv_rst = 1'b0;
    endtask

    task automatic do_reset();
        drv_rst = 1'b1;
        step();
        step();
    endtask

    task automatic wait_gnt(input int max, input string name);
        int n;
        n = 0;
        step();
        while (!last_gnt && n < max) begin
            step();
            n++;
        end
        chk(name, 32'(last_gnt), 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        redir_vec_t vecs[4];
        int base;
        int pbase;

        vecs[0] = '{target: 32'h0000_0100, first: 32'h0000_0100, second: 32'h0000_0104, fault: 1'b0};
        vecs[1] = '{target: 32'hFFFF_FFFC, first: 32'hFFFF_FFFC, second: 32'h0000_0000, fault: 1'b0};
`ifdef IFU_MISALIGN_TRAP_EN
        vecs[2] = '{target: 32'h0000_0102, first: 32'h0, second: 32'h0, fault: 1'b1};
        vecs[3] = '{target: 32'h0000_0FF1, first: 32'h0, second: 32'h0, fault: 1'b1};
`else
        vecs[2] = '{target: 32'h0000_0102, first: 32'h0000_0100, second: 32'h0000_0104, fault: 1'b0};
        vecs[3] = '{target: 32'h0000_0FF1, first: 32'h0000_0FF0, second: 32'h0000_0FF4, fault: 1'b0};
`endif

        // 1: sequential fetch, single-cycle memory, decode always ready
        gnt_delay = 0; rv_extra = 0; drv_ready = 1'b1;
        do_reset();
        chk("req_at_reset_edge", 32'(imem_req), 32'h0);
        base = gnt_log.size();
        pbase = pops;
        step();
        chk("first_req", 32'(imem_req), 32'h1);
        chk("first_addr", imem_addr, ResetPc);
        repeat (39) step();
        for (int i = 0; i < 3; i++) chk("seq_addr", gnt_log[base + i], ResetPc + 32'(4 * i));
        chk("throughput", 32'(pops - pbase >= 18), 32'h1);

        // 2: decode stalled -> exactly BUF_DEPTH fetches, then resume
        drv_ready = 1'b0;
        do_reset();
        base = gnt_log.size();
        repeat (20) step();
        chk("stall_fetches", 32'(gnt_log.size() - base), 32'(TbDepth));
        chk("stall_req_low", 32'(imem_req), 32'h0);
        drv_ready = 1'b1;
        pbase = pops;
        repeat (20) step();
        chk("resume_pops", 32'(pops - pbase >= TbDepth), 32'h1);
        chk("resume_fetch", 32'(gnt_log.size() - base > TbDepth), 32'h1);

        // 3: redirect while waiting for read data
        rv_extra = 2;
        do_reset();
        wait_gnt(20, "t3_gnt");
        drv_target = 32'h0000_0100; drv_redir = 1'b1;
        step();
        step();
        chk("iv_after_redir", 32'(inst_valid), 32'h0);
        wait_gnt(20, "t3_regnt");
        chk("t3_addr", gnt_log[gnt_log.size() - 1], 32'h0000_0100);
        repeat (10) step();

        // 4: redirect coincides with a late grant
        rv_extra = 0; gnt_delay = 3;
        drv_target = 32'h0000_0300; redir_on_gnt = 1'b1;
        wait_gnt(20, "t4_gnt");
        wait_gnt(20, "t4_regnt");
        chk("t4_addr", gnt_log[gnt_log.size() - 1], 32'h0000_0300);
        repeat (10) step();

        // 5: reset while a read is outstanding; stray response must be ignored
        gnt_delay = 0; rv_extra = 2;
        wait_gnt(20, "t5_gnt");
        do_reset();
        chk("t5_iv", 32'(inst_valid), 32'h0);
        wait_gnt(20, "t5_regnt");
        chk("t5_addr", gnt_log[gnt_log.size() - 1], ResetPc);
        repeat (10) step();

        // 6: redirect target table, including wrap and misaligned targets
        rv_extra = 0;
        for (int v = 0; v < 4; v++) begin
            do_reset();
            repeat (3) step();
            drv_target = vecs[v].target; drv_redir = 1'b1;
            step();
            base = gnt_log.size();
            if (vecs[v].fault) begin
                repeat (10) step();
                chk("tbl_fault", 32'(fetch_fault), 32'h1);
                chk("tbl_no_fetch", 32'(gnt_log.size() - base), 32'h0);
                drv_target = 32'h0000_0200; drv_redir = 1'b1;
                step();
                step();
                chk("tbl_fault_clr", 32'(fetch_fault), 32'h0);
                wait_gnt(20, "tbl_clr_gnt");
                chk("tbl_clr_addr", gnt_log[gnt_log.size() - 1], 32'h0000_0200);
            end else begin
                wait_gnt(20, "tbl_gnt1");
                wait_gnt(20, "tbl_gnt2");
                chk("tbl_fault0", 32'(fetch_fault), 32'h0);
                if (gnt_log.size() >= base + 2) begin
                    chk("tbl_first", gnt_log[base], vecs[v].first);
                    chk("tbl_second", gnt_log[base + 1], vecs[v].second);
                end
            end
        end

        // Randomized traffic against the stream model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            gnt_delay = $urandom_range(0, 3);
            rv_extra = $urandom_range(0, 2);
            drv_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 3) begin
                drv_redir = 1'b1;
                drv_target = $urandom & 32'h0000_FFFC;
                if ($urandom_range(0, 7) == 0) drv_target[1:0] = 2'($urandom_range(1, 3));
            end else if ($urandom_range(0, 999) < 3) begin
                drv_rst = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
